interleaved_fifo_bank_sched: RTL and testbench

//  Access scheduler for an interleaved sync FIFO built from NUM_BANKS single-port RAM banks.

---
 rtl/interleaved_fifo_pkg.sv | 32 +++
 rtl/bank_conflict_arb.sv | 47 ++++
 rtl/interleaved_fifo_bank_sched.sv | 158 +++++++++++++++
 tb/tb_interleaved_fifo_bank_sched.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/interleaved_fifo_pkg.sv
// Shared definitions for the interleaved FIFO bank scheduler.
//  - Default configuration constants used as parameter defaults by the top.
//  - Width helpers: PW (pointer), BW (bank index), AW (per-bank address).
//  - bank_idx_t: bank index type for the default configuration.
//  - prio_e: which requester wins the next same-bank conflict.
package interleaved_fifo_pkg;

    localparam int DEF_FIFO_DEPTH = 256;
    localparam int DEF_NUM_BANKS  = 2;
    localparam int DEF_OBUF_DEPTH = 2;
    localparam int DEF_BW         = $clog2(DEF_NUM_BANKS);

    function automatic int calc_pw(input int depth);
        return $clog2(depth);
    endfunction

    function automatic int calc_bw(input int banks);
        return $clog2(banks);
    endfunction

    function automatic int calc_aw(input int depth, input int banks);
        return $clog2(depth) - $clog2(banks);
    endfunction

    typedef logic [DEF_BW-1:0] bank_idx_t;

    typedef enum logic {
        PRIO_READ  = 1'b0,
        PRIO_WRITE = 1'b1
    } prio_e;

endpackage

// File: rtl/bank_conflict_arb.sv
// Two-requester toggle-priority arbiter for a single-port bank.
// Without a conflict both requests are granted (they target different banks).
// On a conflict the current priority holder wins and priority flips, so a
// sustained conflict alternates read and write grants.
// Ports:
//  clk, rst  clock and synchronous active-high reset (priority returns to READ)
//  req_rd    read wants to issue
//  req_wr    write wants to issue
//  conflict  both requests target the same bank this cycle
//  gnt_rd    read issues this cycle
//  gnt_wr    write issues this cycle
//  prio      arbiter state: requester that wins the next conflict
module bank_conflict_arb
    import interleaved_fifo_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  req_rd,
    input  logic  req_wr,
    input  logic  conflict,
    output logic  gnt_rd,
    output logic  gnt_wr,
    output prio_e prio
);

    prio_e prio_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            prio <= PRIO_READ;
        end else begin
            prio <= prio_next;
        end
    end

    always_comb begin
        prio_next = prio;
        gnt_rd    = req_rd;
        gnt_wr    = req_wr;
        if (conflict) begin
            gnt_rd    = req_rd && (prio == PRIO_READ);
            gnt_wr    = req_wr && (prio == PRIO_WRITE);
            prio_next = (prio == PRIO_READ) ? PRIO_WRITE : PRIO_READ;
        end
    end

endmodule

// File: rtl/interleaved_fifo_bank_sched.sv
// Access scheduler for an interleaved synchronous FIFO built from NUM_BANKS
// single-port RAM banks. Entry i lives in bank i%NUM_BANKS, address
// i/NUM_BANKS. Issues per-bank write/read strobes, resolves same-bank
// conflicts through a toggle-priority arbiter, tracks occupancy, and meters
// reads with credits for an external output buffer.
// Ports:
//  clk, rst     clock, synchronous active-high reset
//  in_valid     producer offers a word (data is routed to all banks outside)
//  in_ready     write accepted this cycle when in_valid && in_ready
//  obuf_pop     output buffer released a slot; returns one read credit
//  bank_en      per-bank access strobe
//  bank_we      per-bank write enable (meaningful only with bank_en)
//  bank_addr    per-bank address, bank b at [b*AW +: AW]
//  rd_vld       registered: RAM read data valid this cycle
//  rd_bank      registered: bank whose read data is valid
//  cnt          entries held in the banks (output buffer excluded)
//  almost_full  cnt >= FIFO_DEPTH-1
//
// Handshake: a write transfers on a cycle where in_valid && in_ready are both
// high at the rising edge. in_ready is computed from internal state only and
// never looks at in_valid, so the producer may hold in_valid until accepted.
module interleaved_fifo_bank_sched
    import interleaved_fifo_pkg::*;
#(
    parameter  int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter  int NUM_BANKS  = DEF_NUM_BANKS,
    parameter  int OBUF_DEPTH = DEF_OBUF_DEPTH,
    localparam int PW = calc_pw(FIFO_DEPTH),
    localparam int BW = calc_bw(NUM_BANKS),
    localparam int AW = calc_aw(FIFO_DEPTH, NUM_BANKS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  obuf_pop,
    output logic [NUM_BANKS-1:0]  bank_en,
    output logic [NUM_BANKS-1:0]  bank_we,
    output logic [NUM_BANKS*AW-1:0] bank_addr,
    output logic                  rd_vld,
    output logic [BW-1:0]         rd_bank,
    output logic [PW:0]           cnt,
    output logic                  almost_full
);

    localparam int            CW        = $clog2(OBUF_DEPTH + 1);
    localparam logic [PW:0]   FULL_CNT  = (PW+1)'(FIFO_DEPTH);
    localparam logic [PW:0]   AF_CNT    = (PW+1)'(FIFO_DEPTH - 1);
    localparam logic [PW:0]   CNT_ONE   = (PW+1)'(1);
    localparam logic [PW-1:0] PTR_ONE   = PW'(1);
    localparam logic [CW-1:0] CRED_FULL = CW'(OBUF_DEPTH);
    localparam logic [CW-1:0] CRED_ONE  = CW'(1);

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] credit;
    logic [PW:0]   cnt_next;
    logic [CW-1:0] credit_next;

    logic [BW-1:0] wr_bank_sel;
    logic [BW-1:0] rd_bank_sel;
    logic [AW-1:0] wr_addr;
    logic [AW-1:0] rd_addr;
    logic          same_bank;
    logic          rd_want;
    logic          wr_want;
    logic          conflict;
    logic          rd_fire;
    logic          wr_fire;
    prio_e         prio;

    assign wr_bank_sel = wr_ptr[BW-1:0];
    assign rd_bank_sel = rd_ptr[BW-1:0];
    assign wr_addr     = wr_ptr[PW-1:BW];
    assign rd_addr     = rd_ptr[PW-1:BW];
    assign same_bank   = (wr_bank_sel == rd_bank_sel);

    // Both wants are forced low during reset so no strobe leaves the block
    // and the arbiter sees no conflict.
    assign rd_want  = !rst && (cnt != '0) && (credit != '0);
    assign wr_want  = !rst && in_valid && (cnt != FULL_CNT);
    assign conflict = rd_want && wr_want && same_bank;

    // Would lose a same-bank conflict to a pending read: refuse up front so
    // in_ready stays independent of in_valid.
    assign in_ready    = !rst && (cnt != FULL_CNT) &&
                         !(rd_want && same_bank && (prio == PRIO_READ));
    assign almost_full = (cnt >= AF_CNT);

    bank_conflict_arb u_arb (
        .clk      (clk),
        .rst      (rst),
        .req_rd   (rd_want),
        .req_wr   (wr_want),
        .conflict (conflict),
        .gnt_rd   (rd_fire),
        .gnt_wr   (wr_fire),
        .prio     (prio)
    );

    always_comb begin
        bank_en   = '0;
        bank_we   = '0;
        bank_addr = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (wr_fire && (wr_bank_sel == BW'(b))) begin
                bank_en[b]            = 1'b1;
                bank_we[b]            = 1'b1;
                bank_addr[b*AW +: AW] = wr_addr;
            end
            if (rd_fire && (rd_bank_sel == BW'(b))) begin
                bank_en[b]            = 1'b1;
                bank_addr[b*AW +: AW] = rd_addr;
            end
        end
    end

    always_comb begin
        case ({wr_fire, rd_fire})
            2'b10:   cnt_next = cnt + CNT_ONE;
            2'b01:   cnt_next = cnt - CNT_ONE;
            default: cnt_next = cnt;
        endcase
        case ({rd_fire, obuf_pop})
            2'b10:   credit_next = credit - CRED_ONE;
            2'b01:   credit_next = credit + CRED_ONE;
            default: credit_next = credit;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            cnt     <= '0;
            credit  <= CRED_FULL;
            rd_vld  <= 1'b0;
            rd_bank <= '0;
        end else begin
            if (wr_fire) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_fire) begin
                rd_ptr  <= rd_ptr + PTR_ONE;
                rd_bank <= rd_bank_sel;
            end
            cnt    <= cnt_next;
            credit <= credit_next;
            rd_vld <= rd_fire;
        end
    end

    // A pop with every credit already home means the output buffer released a
    // slot it never held.
    credit_overflow_a: assert property (@(posedge clk) disable iff (rst)
        !(obuf_pop && (credit == CRED_FULL)));

endmodule

// File: tb/tb_interleaved_fifo_bank_sched.sv
// Self-checking bench for interleaved_fifo_bank_sched (256 entries, 2 banks,
// 2 output-buffer credits). A small RAM model stores the write sequence
// number at whatever bank/address the DUT strobes; the expected queue holds
// sequence numbers in acceptance order and is popped when rd_vld appears.
module tb_interleaved_fifo_bank_sched;

  localparam int DEPTH = 256;
  localparam int NB    = 2;
  localparam int OBUF  = 2;
  localparam int PW    = 8;
  localparam int BW    = 1;
  localparam int AW    = 7;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic                 obuf_pop = 1'b0;
  logic [NB-1:0]        bank_en;
  logic [NB-1:0]        bank_we;
  logic [NB*AW-1:0]     bank_addr;
  logic                 rd_vld;
  logic [BW-1:0]        rd_bank;
  logic [PW:0]          cnt;
  logic                 almost_full;

  interleaved_fifo_bank_sched #(
    .FIFO_DEPTH (DEPTH),
    .NUM_BANKS  (NB),
    .OBUF_DEPTH (OBUF)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .obuf_pop    (obuf_pop),
    .bank_en     (bank_en),
    .bank_we     (bank_we),
    .bank_addr   (bank_addr),
    .rd_vld      (rd_vld),
    .rd_bank     (rd_bank),
    .cnt         (cnt),
    .almost_full (almost_full)
  );

  // ---------------- scoreboard state ----------------
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] ram [NB][DEPTH/NB];
  int          wr_seq = 0;
  int          rd_seq = 0;
  int          model_cnt = 0;
  int          model_credit = OBUF;
  logic        pend_valid = 1'b0;
  logic [31:0] pend_data = '0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // ---------------- monitor / RAM model (mid-cycle) ----------------
  always @(negedge clk) begin : monitor
    int n_wr, n_rd, wb, wa, rb, ra;
    logic [31:0] e;
    if (rst) begin
      check_eq("rst_in_ready", 32'(in_ready), 0);
      check_eq("rst_bank_en", 32'(bank_en), 0);
      exp_q.delete();
      wr_seq       = 0;
      rd_seq       = 0;
      model_cnt    = 0;
      model_credit = OBUF;
      pend_valid   = 1'b0;
    end else begin
      check_eq("cnt", 32'(cnt), model_cnt);
      check_eq("almost_full", 32'(almost_full), (model_cnt >= DEPTH - 1) ? 1 : 0);
      if (rd_vld || pend_valid) begin
        check_eq("rd_vld", 32'(rd_vld), 32'(pend_valid));
        if (rd_vld && pend_valid) begin
          e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
          check_eq("rd_bank", 32'(rd_bank), e % NB);
          check_eq("rd_data", pend_data, e);
        end
      end
      n_wr = 0; n_rd = 0; wb = 0; wa = 0; rb = 0; ra = 0;
      for (int b = 0; b < NB; b++) begin
        if (bank_en[b] && bank_we[b]) begin
          n_wr++; wb = b; wa = int'(bank_addr[b*AW +: AW]);
        end
        if (bank_en[b] && !bank_we[b]) begin
          n_rd++; rb = b; ra = int'(bank_addr[b*AW +: AW]);
        end
      end
      check_eq("wr_strobe", n_wr, (in_valid && in_ready) ? 1 : 0);
      if (n_wr == 1) begin
        check_eq("wr_bank", wb, wr_seq % NB);
        check_eq("wr_addr", wa, (wr_seq % DEPTH) / NB);
        ram[wb][wa] = wr_seq;
        exp_q.push_back(wr_seq);
        wr_seq++;
      end
      pend_valid = 1'b0;
      if (n_rd != 0) begin
        check_eq("rd_legal", (model_cnt != 0 && model_credit != 0) ? 1 : 0, 1);
        check_eq("rd_single", n_rd, 1);
        check_eq("rd_issue_bank", rb, rd_seq % NB);
        check_eq("rd_addr", ra, (rd_seq % DEPTH) / NB);
        pend_data  = ram[rb][ra];
        pend_valid = 1'b1;
        rd_seq++;
      end
      model_cnt    = model_cnt + n_wr - n_rd;
      model_credit = model_credit + (obuf_pop ? 1 : 0) - n_rd;
    end
  end

  // ---------------- driver tasks ----------------
  // One cycle: drive just after the rising edge, return mid-cycle after the
  // monitor has run. Pops are only offered while a credit is outstanding.
  task automatic drive_cycle(input logic v, input logic p);
    @(posedge clk); #1;
    in_valid = v;
    obuf_pop = p && (model_credit < OBUF);
    @(negedge clk); #1;
  endtask

  task automatic apply_reset();
    @(posedge clk); #1;
    rst      = 1'b1;
    in_valid = 1'b1;
    obuf_pop = 1'b1;
    @(posedge clk); #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    obuf_pop = 1'b0;
    @(negedge clk); #1;
  endtask

  task automatic step_chk(input string tag, input logic v, input logic p,
                          input int e_rdy, input int e_rd, input int e_wr);
    int r0, w0;
    r0 = rd_seq;
    w0 = wr_seq;
    drive_cycle(v, p);
    check_eq({tag, "_ready"}, 32'(in_ready), e_rdy);
    check_eq({tag, "_rd"}, rd_seq - r0, e_rd);
    check_eq({tag, "_wr"}, wr_seq - w0, e_wr);
  endtask

  task automatic drain(input string tag);
    int guard;
    guard = 0;
    while ((model_cnt != 0 || pend_valid || rd_vld) && guard < 1000) begin
      drive_cycle(1'b0, 1'b1);
      guard++;
    end
    repeat (3) drive_cycle(1'b0, 1'b1);
    check_eq({tag, "_cnt"}, 32'(cnt), 0);
    check_eq({tag, "_rd_vld"}, 32'(rd_vld), 0);
    check_eq({tag, "_q_empty"}, exp_q.size(), 0);
  endtask

  // ---------------- scenarios ----------------
  initial begin
    int guard;

    // Reset state (pops and in_valid offered during reset are ignored)
    apply_reset();
    check_eq("reset_cnt", 32'(cnt), 0);
    check_eq("reset_rd_vld", 32'(rd_vld), 0);
    check_eq("reset_af", 32'(almost_full), 0);
    check_eq("reset_in_ready", 32'(in_ready), 1);

    // Fill with no pops: two credit-limited reads, then writes until full
    guard = 0;
    do begin
      drive_cycle(1'b1, 1'b0);
      guard++;
    end while (in_ready && guard < 400);
    check_eq("fill_stall", 32'(in_ready), 0);
    check_eq("fill_cnt", 32'(cnt), DEPTH);
    check_eq("fill_af", 32'(almost_full), 1);
    check_eq("fill_reads", rd_seq, OBUF);
    check_eq("fill_writes", wr_seq, DEPTH + OBUF);

    // Full with a pop: in_ready stays low until the read fires
    step_chk("full_pop", 1'b1, 1'b1, 0, 0, 0);
    step_chk("full_rd", 1'b1, 1'b0, 0, 1, 0);
    step_chk("full_resume", 1'b1, 1'b0, 1, 0, 1);
    check_eq("full_cnt_255", 32'(cnt), DEPTH - 1);

    // Drain everything in write order across the pointer wrap
    drain("drain1");
    check_eq("drain1_order", rd_seq, wr_seq);

    // Same-bank conflicts: read, write, read
    apply_reset();
    repeat (4) drive_cycle(1'b1, 1'b0);
    drive_cycle(1'b0, 1'b1);
    step_chk("cf1", 1'b1, 1'b0, 0, 1, 0);
    step_chk("cf_gap", 1'b1, 1'b1, 1, 0, 1);
    step_chk("cf2", 1'b1, 1'b0, 1, 0, 1);
    step_chk("cf_rd", 1'b0, 1'b0, 1, 1, 0);
    drive_cycle(1'b0, 1'b1);
    step_chk("cf3", 1'b1, 1'b0, 0, 1, 0);
    drain("drain2");

    // Steady stream at cnt=127 (opposite banks): 1 write + 1 read per cycle
    guard = 0;
    while (model_cnt < 128 && guard < 400) begin
      drive_cycle(1'b1, 1'b0);
      guard++;
    end
    check_eq("hf_fill", model_cnt, 128);
    step_chk("hf_a", 1'b0, 1'b1, 1, 0, 0);
    step_chk("hf_b", 1'b0, 1'b1, 1, 1, 0);
    for (int i = 0; i < 32; i++) begin
      step_chk("steady", 1'b1, 1'b1, 1, 1, 1);
    end
    check_eq("steady_cnt", 32'(cnt), 127);
    check_eq("pre_rst_vld", 32'(rd_vld), 1);

    // Reset mid-stream
    apply_reset();
    check_eq("mid_rst_vld", 32'(rd_vld), 0);
    check_eq("mid_rst_cnt", 32'(cnt), 0);
    check_eq("mid_rst_en", 32'(bank_en), 0);
    step_chk("fresh_wr", 1'b1, 1'b0, 1, 0, 1);
    check_eq("fresh_wr_en", 32'(bank_en), 1);
    check_eq("fresh_wr_we", 32'(bank_we), 1);
    check_eq("fresh_wr_addr", 32'(bank_addr), 0);
    step_chk("fresh_rd", 1'b0, 1'b0, 1, 1, 0);
    check_eq("fresh_rd_en", 32'(bank_en), 1);
    check_eq("fresh_rd_we", 32'(bank_we), 0);
    check_eq("fresh_rd_addr", 32'(bank_addr), 0);
    // Exactly two credits after reset: the third stored word must wait
    step_chk("cred_w", 1'b1, 1'b0, 1, 0, 1);
    step_chk("cred_r", 1'b0, 1'b0, 1, 1, 0);
    step_chk("cred_w2", 1'b1, 1'b0, 1, 0, 1);
    step_chk("cred_empty", 1'b0, 1'b0, 1, 0, 0);
    drain("drain3");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
